// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and helpers for the 10's-complement BCD decoder.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] SIGN_POS = 4'h0;
    localparam logic [DIGIT_W-1:0] SIGN_NEG = 4'h9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        ADJ  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_mac.sv
// One decimal step of the conversion: acc*10 + digit via shift-add, plus a
// flag for a nibble that is not a decimal digit.
module bcd_digit_mac
    import bcd_pkg::*;
#(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [ACC_W-1:0]   acc_next,
    output logic               digit_bad
);

    assign acc_next  = (acc << 3) + (acc << 1) + ACC_W'(digit);
    assign digit_bad = (digit > 4'd9);

endmodule

// File: rtl/bcd_tc_to_bin.sv
// Digit-serial decoder from sign-digit 10's-complement BCD to two's-complement binary.
//
// state | meaning
// IDLE  | in_ready high, waiting for a word
// CONV  | one magnitude digit per edge folded into acc, MSD first
// ADJ   | apply sign / error, load result registers
// DONE  | result held until out_ready
module bcd_tc_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int W      = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*(DIGITS+1)-1:0] bcd_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [W-1:0]           bin_out,
    output logic                          err
);

    localparam int MAG_W = DIGIT_W * DIGITS;
    localparam int ACC_W = $clog2(pow10(DIGITS));
    localparam int CNT_W = $clog2(DIGITS + 1);
    localparam logic [W-1:0] BIAS = W'(pow10(DIGITS));

    state_t             state_q, state_d;
    logic [MAG_W-1:0]   shreg_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               err_q;
    logic               digit_bad;
    logic [DIGIT_W-1:0] sign;
    logic [DIGIT_W-1:0] msd;

    assign sign     = bcd_in[DIGIT_W*(DIGITS+1)-1 -: DIGIT_W];
    assign msd      = shreg_q[MAG_W-1 -: DIGIT_W];
    assign in_ready = (state_q == IDLE);

    bcd_digit_mac #(.ACC_W(ACC_W)) u_mac (
        .acc       (acc_q),
        .digit     (msd),
        .acc_next  (acc_next),
        .digit_bad (digit_bad)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = CONV;
            CONV:    if (cnt_q == '0) state_d = ADJ;
            ADJ:     state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            err_q     <= 1'b0;
            bin_out   <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shreg_q <= bcd_in[MAG_W-1:0];
                        acc_q   <= '0;
                        cnt_q   <= CNT_W'(DIGITS - 1);
                        neg_q   <= (sign == SIGN_NEG);
                        err_q   <= (sign != SIGN_POS) && (sign != SIGN_NEG);
                    end
                end
                CONV: begin
                    // Bad digits are caught as they pass the MAC; every digit of the word
                    // is seen before ADJ, so the flag is complete when it is used.
                    acc_q   <= acc_next;
                    shreg_q <= shreg_q << DIGIT_W;
                    cnt_q   <= cnt_q - CNT_W'(1);
                    err_q   <= err_q | digit_bad;
                end
                ADJ: begin
                    bin_out   <= err_q ? '0 : (neg_q ? W'(acc_q) - BIAS : W'(acc_q));
                    err       <= err_q;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_tc_to_bin.sv
// Scoreboard bench for bcd_tc_to_bin: expected results queued on issue, checked on output.
module tb_bcd_tc_to_bin;

    localparam int DIGITS = 3;
    localparam int W      = 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [15:0]         bcd_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] bin_out;
    logic                err;

    typedef struct {
        int bin;
        int err;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_acc = 0;

    bcd_tc_to_bin #(.DIGITS(DIGITS), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one word, check latency and result, then release it.
    // ivl > 0 also checks the accept-to-accept spacing; stall > 0 holds out_ready low
    // that many cycles while a new word waits on in_valid.
    task automatic send(input logic [15:0] w, input int eb, input int ee,
                        input bit early_rdy, input int ivl, input int stall);
        exp_t e;
        int   n;
        e.bin = eb;
        e.err = ee;
        exp_q.push_back(e);
        bcd_in   = w;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check_val("accept_timeout", 0, 1);
            in_valid = 1'b0;
            exp_q.delete(exp_q.size() - 1);
            return;
        end
        @(posedge clk); #1;
        if (ivl > 0) check_val("issue_interval", cyc - last_acc, ivl);
        last_acc = cyc;
        in_valid = 1'b0;
        if (early_rdy) out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("latency", n, DIGITS + 1);
        if (!out_valid) return;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        check_val("bin_out", int'(bin_out), e.bin);
        check_val("err", int'(err), e.err);
        if (stall > 0) begin
            bcd_in   = 16'h0555;
            in_valid = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                check_val("stall_bin", int'(bin_out), e.bin);
                check_val("stall_err", int'(err), e.err);
                check_val("stall_valid", int'(out_valid), 1);
                check_val("stall_in_ready", int'(in_ready), 0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("release_in_ready", int'(in_ready), 1);
        check_val("release_valid", int'(out_valid), 0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_err", int'(err), 0);
        check_val("rst_bin", int'(bin_out), 0);
        check_val("rst_in_ready", int'(in_ready), 1);

        send(16'h0999,   999, 0, 1'b0, 0, 0);
        send(16'h9001,  -999, 0, 1'b0, 0, 0);
        send(16'h9000, -1000, 0, 1'b0, 0, 0);
        send(16'h9667,  -333, 0, 1'b0, 0, 0);
        send(16'h0000,     0, 0, 1'b0, 0, 0);
        send(16'h00A5,     0, 1, 1'b0, 0, 0);
        send(16'h5123,     0, 1, 1'b0, 0, 0);
        send(16'h0321,   321, 0, 1'b1, 0, 0);
        send(16'h9679,  -321, 0, 1'b1, DIGITS + 3, 0);
        send(16'h0123,   123, 0, 1'b0, 0, 10);
        send(16'h0555,   555, 0, 1'b0, 0, 0);
        send(16'h9667,  -333, 0, 1'b0, 0, 0);

        // Reset lands on the second CONV edge of an in-flight word.
        bcd_in   = 16'h0999;
        in_valid = 1'b1;
        check_val("mid_rst_ready", int'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("mid_rst_valid", int'(out_valid), 0);
        check_val("mid_rst_err", int'(err), 0);
        check_val("mid_rst_bin", int'(bin_out), 0);
        check_val("mid_rst_in_ready", int'(in_ready), 1);
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        check_val("mid_rst_no_output", n, 0);

        send(16'h0042, 42, 0, 1'b0, 0, 0);

        check_val("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
